// File: rtl/relobi_encoder_mon_pkg.sv
// Shared types and helpers for the relOBI encoder/monitor.
// Holds the plain OBI and relOBI bus structs, the fault-event struct, the
// default counter width, a Hsiao SEC-DED code over 32-bit words (7 check
// bits) and the TMR majority/disagreement helpers.
// Narrow fields are zero-padded to 32 bits before encoding.
package relobi_encoder_mon_pkg;

  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;
  localparam int ID_W          = 4;
  localparam int BE_W          = 4;
  localparam int ECC_W         = 7;
  localparam int R_OTHER_W     = ID_W + 1;
  localparam int CNT_W_DEFAULT = 16;

  typedef struct packed {
    logic tmr;
    logic corr;
    logic uncorr;
    logic proto;
  } fault_evt_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ID_W-1:0]   aid;
    logic [DATA_W-1:0] wdata;
  } obi_a_t;

  typedef struct packed {
    logic   req;
    obi_a_t a;
    logic   rready;
  } obi_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic [ID_W-1:0]   rid;
    logic              err;
  } obi_r_t;

  typedef struct packed {
    logic   gnt;
    logic   rvalid;
    obi_r_t r;
  } obi_rsp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ECC_W-1:0]  addr_ecc;
    logic [DATA_W-1:0] wdata;
    logic [ECC_W-1:0]  wdata_ecc;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ID_W-1:0]   aid;
    logic [ECC_W-1:0]  other_ecc;
  } rel_a_t;

  typedef struct packed {
    logic [2:0] req;
    rel_a_t     a;
    logic [2:0] rready;
  } relobi_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic [ECC_W-1:0]  rdata_ecc;
    logic [ID_W-1:0]   rid;
    logic              err;
    logic [ECC_W-1:0]  other_ecc;
  } rel_r_t;

  typedef struct packed {
    logic [2:0] gnt;
    logic [2:0] rvalid;
    rel_r_t     r;
  } relobi_rsp_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              corr;
    logic              uncorr;
  } hsiao_dec_t;

  // Column idx of the parity-check matrix: the idx-th weight-3 value in
  // ascending order. Odd-weight columns let even syndromes flag double errors.
  function automatic logic [ECC_W-1:0] hsiao_col(input int idx);
    int n;
    logic [ECC_W-1:0] col;
    n   = 0;
    col = '0;
    for (int v = 0; v < (1 << ECC_W); v++) begin
      if ($countones(v[ECC_W-1:0]) == 3) begin
        if (n == idx) col = v[ECC_W-1:0];
        n++;
      end
    end
    return col;
  endfunction

  function automatic logic [ECC_W-1:0] hsiao_enc(input logic [DATA_W-1:0] d);
    logic [ECC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (d[i]) c = c ^ hsiao_col(i);
    end
    return c;
  endfunction

  function automatic hsiao_dec_t hsiao_dec(input logic [DATA_W-1:0] d,
                                           input logic [ECC_W-1:0]  c);
    logic [ECC_W-1:0] syn;
    hsiao_dec_t       r;
    syn      = hsiao_enc(d) ^ c;
    r.data   = d;
    r.corr   = 1'b0;
    r.uncorr = 1'b0;
    if (syn != '0) begin
      if (($countones(syn) % 2) == 0) begin
        r.uncorr = 1'b1;
      end else begin
        // Weight-1 syndrome: the flipped bit is a check bit, data is intact.
        r.corr = ($countones(syn) == 1);
        for (int i = 0; i < DATA_W; i++) begin
          if (hsiao_col(i) == syn) begin
            r.data[i] = ~d[i];
            r.corr    = 1'b1;
          end
        end
        if (!r.corr) r.uncorr = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic rel_a_t encode_a(input obi_a_t a);
    rel_a_t e;
    e.addr      = a.addr;
    e.addr_ecc  = hsiao_enc(a.addr);
    e.wdata     = a.wdata;
    e.wdata_ecc = hsiao_enc(a.wdata);
    e.we        = a.we;
    e.be        = a.be;
    e.aid       = a.aid;
    e.other_ecc = hsiao_enc(DATA_W'({a.we, a.be, a.aid}));
    return e;
  endfunction

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  function automatic logic tmr_mis(input logic [2:0] v);
    return (|v) & ~(&v);
  endfunction

endpackage

// File: rtl/relobi_encoder_mon_if.sv
// Bus bundle for one manager-to-relOBI boundary.
//   req/rsp         : plain OBI manager side
//   rel_req/rel_rsp : reliable OBI side (TMR handshake, ECC fields)
// slave  : the encoder view (takes the manager request, drives relOBI)
// master : the manager/fabric view used by whoever drives the encoder
interface relobi_encoder_mon_if;
  import relobi_encoder_mon_pkg::*;

  obi_req_t    req;
  obi_rsp_t    rsp;
  relobi_req_t rel_req;
  relobi_rsp_t rel_rsp;

  modport slave  (input  req, rel_rsp, output rsp, rel_req);
  modport master (output req, rel_rsp, input  rsp, rel_req);
endinterface

// File: rtl/relobi_sat_counter.sv
// Saturating event counter with synchronous clear.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : clear; the counter restarts at 1 if evt_i is also set
//   evt_i        : one increment per cycle
//   cnt_o        : count, sticks at all-ones
module relobi_sat_counter #(
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                evt_i,
  output logic [CntWidth-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clear_i) begin
      cnt_o <= CntWidth'(evt_i);
    end else if (evt_i && !(&cnt_o)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/relobi_encoder_mon.sv
// Plain OBI to relOBI encoder with fault monitoring.
// Encodes the A channel with Hsiao ECC and triplicates the request, votes
// the returned gnt/rvalid, ECC-corrects the response, limits outstanding
// transactions and counts TMR, correctable, uncorrectable and protocol
// faults with a sticky interrupt.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   bus           : slave view of the OBI/relOBI bundle
//   clear_i       : clears the fault counters and irq_o
//   *_cnt_o       : saturating fault counters
//   irq_o         : sticky fault interrupt
module relobi_encoder_mon
  import relobi_encoder_mon_pkg::*;
#(
  parameter bit          RegisterReq    = 1'b0,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntWidth       = CNT_W_DEFAULT,
  parameter bit          UseRReady      = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  relobi_encoder_mon_if.slave bus,
  input  logic                clear_i,
  output logic [CntWidth-1:0] tmr_cnt_o,
  output logic [CntWidth-1:0] corr_cnt_o,
  output logic [CntWidth-1:0] uncorr_cnt_o,
  output logic [CntWidth-1:0] proto_cnt_o,
  output logic                irq_o
);

  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

  logic [OutW-1:0] out_cnt_q;
  logic            gnt_v, rvalid_v, limit;
  logic            a_hs, r_hs, gnt_o, rel_vld;
  logic            pad_err;
  rel_a_t          enc_a, rel_a;
  hsiao_dec_t      rdata_dec, rother_dec;
  fault_evt_t      evt;

  assign enc_a    = encode_a(bus.req.a);
  assign gnt_v    = maj3(bus.rel_rsp.gnt);
  assign rvalid_v = maj3(bus.rel_rsp.rvalid);
  assign limit    = (out_cnt_q == OutW'(MaxOutstanding));

  if (RegisterReq) begin : g_reg
    logic   vld_p1;
    rel_a_t a_p1;
    logic   load;

    // A gnt to the manager either fills an empty slot or replaces the entry
    // leaving downstream this cycle, so back-to-back requests stream.
    assign gnt_o   = ~vld_p1 | (gnt_v & ~limit);
    assign load    = bus.req.req & gnt_o;
    assign a_hs    = vld_p1 & ~limit & gnt_v;
    assign rel_vld = vld_p1 & ~limit;
    assign rel_a   = a_p1;

    // ---- stage p1: encoded A channel held for the relOBI side ----
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_p1 <= 1'b0;
      end else if (load) begin
        vld_p1 <= 1'b1;
      end else if (a_hs) begin
        vld_p1 <= 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (load) a_p1 <= enc_a;
    end
  end else begin : g_comb
    assign gnt_o   = gnt_v & ~limit;
    assign rel_vld = bus.req.req & ~limit;
    assign a_hs    = rel_vld & gnt_v;
    assign rel_a   = enc_a;
  end

  assign r_hs = rvalid_v & (bus.req.rready | ~UseRReady);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt_q <= '0;
    end else begin
      case ({a_hs, r_hs})
        2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
        2'b01:   if (out_cnt_q != '0) out_cnt_q <= out_cnt_q - 1'b1;
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

  assign bus.rel_req.req    = {3{rel_vld}};
  assign bus.rel_req.a      = rel_a;
  assign bus.rel_req.rready = {3{bus.req.rready}};

  assign rdata_dec  = hsiao_dec(bus.rel_rsp.r.rdata, bus.rel_rsp.r.rdata_ecc);
  assign rother_dec = hsiao_dec(DATA_W'({bus.rel_rsp.r.rid, bus.rel_rsp.r.err}),
                                bus.rel_rsp.r.other_ecc);
  // A "correction" landing in the zero padding means more than one bit flipped.
  assign pad_err    = |rother_dec.data[DATA_W-1:R_OTHER_W];

  assign bus.rsp.gnt     = gnt_o;
  assign bus.rsp.rvalid  = rvalid_v;
  assign bus.rsp.r.rdata = rdata_dec.data;
  assign bus.rsp.r.rid   = rother_dec.data[R_OTHER_W-1:1];
  assign bus.rsp.r.err   = rother_dec.data[0];

  assign evt.tmr    = tmr_mis(bus.rel_rsp.gnt) | tmr_mis(bus.rel_rsp.rvalid);
  assign evt.corr   = rvalid_v & (rdata_dec.corr | (rother_dec.corr & ~pad_err));
  assign evt.uncorr = rvalid_v & (rdata_dec.uncorr | rother_dec.uncorr | pad_err);
  assign evt.proto  = r_hs & (out_cnt_q == '0);

  relobi_sat_counter #(.CntWidth(CntWidth)) u_tmr_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .evt_i(evt.tmr), .cnt_o(tmr_cnt_o)
  );
  relobi_sat_counter #(.CntWidth(CntWidth)) u_corr_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .evt_i(evt.corr), .cnt_o(corr_cnt_o)
  );
  relobi_sat_counter #(.CntWidth(CntWidth)) u_uncorr_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .evt_i(evt.uncorr), .cnt_o(uncorr_cnt_o)
  );
  relobi_sat_counter #(.CntWidth(CntWidth)) u_proto_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .evt_i(evt.proto), .cnt_o(proto_cnt_o)
  );

  // An event in the same cycle as clear_i keeps the interrupt asserted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_o <= 1'b0;
    end else if (|evt) begin
      irq_o <= 1'b1;
    end else if (clear_i) begin
      irq_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relobi_encoder_mon.sv
module tb_relobi_encoder_mon;
  import relobi_encoder_mon_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clear0, clear1;
  logic [1:0]  tmr0, corr0, uncorr0, proto0;
  logic        irq0;
  logic [15:0] tmr1, corr1, uncorr1, proto1;
  logic        irq1;

  relobi_encoder_mon_if bus0 ();
  relobi_encoder_mon_if bus1 ();

  relobi_encoder_mon #(.RegisterReq(1'b0), .MaxOutstanding(2), .CntWidth(2), .UseRReady(1'b1)) u0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0), .clear_i(clear0),
    .tmr_cnt_o(tmr0), .corr_cnt_o(corr0), .uncorr_cnt_o(uncorr0), .proto_cnt_o(proto0),
    .irq_o(irq0)
  );

  relobi_encoder_mon #(.RegisterReq(1'b1), .MaxOutstanding(4), .CntWidth(16), .UseRReady(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1), .clear_i(clear1),
    .tmr_cnt_o(tmr1), .corr_cnt_o(corr1), .uncorr_cnt_o(uncorr1), .proto_cnt_o(proto1),
    .irq_o(irq1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  rel_a_t exp_a0[$];
  rel_a_t exp_a1[$];
  obi_r_t exp_r0[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Independent Hsiao model: columns enumerated as bit triples (a<b<c),
  // c-major, which is the same as ascending weight-3 values.
  function automatic logic [6:0] model_enc(input logic [31:0] d);
    logic [6:0] p;
    int idx;
    p   = '0;
    idx = 0;
    for (int c = 2; c < 7; c++)
      for (int b = 1; b < c; b++)
        for (int a = 0; a < b; a++) begin
          if (idx < 32) begin
            if (d[idx]) p = p ^ (7'(1 << a) | 7'(1 << b) | 7'(1 << c));
          end
          idx++;
        end
    return p;
  endfunction

  function automatic obi_a_t mk_a(input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic we, input logic [3:0] be, input logic [3:0] aid);
    obi_a_t a;
    a.addr = addr; a.wdata = wdata; a.we = we; a.be = be; a.aid = aid;
    return a;
  endfunction

  function automatic rel_a_t model_a(input obi_a_t a);
    rel_a_t m;
    m.addr      = a.addr;
    m.addr_ecc  = model_enc(a.addr);
    m.wdata     = a.wdata;
    m.wdata_ecc = model_enc(a.wdata);
    m.we        = a.we;
    m.be        = a.be;
    m.aid       = a.aid;
    m.other_ecc = model_enc({23'b0, a.we, a.be, a.aid});
    return m;
  endfunction

  function automatic logic tb_maj(input logic [2:0] g);
    return (g[0] & g[1]) | (g[0] & g[2]) | (g[1] & g[2]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req0(input logic r, input obi_a_t a, input logic push);
    bus0.req.req = r;
    bus0.req.a   = a;
    if (push) exp_a0.push_back(model_a(a));
  endtask

  task automatic drive_req1(input logic r, input obi_a_t a, input logic push);
    bus1.req.req = r;
    bus1.req.a   = a;
    if (push) exp_a1.push_back(model_a(a));
  endtask

  // Response on u0: data carries ECC of the clean word, then flip is applied.
  task automatic drive_rsp0(input logic [2:0] rv, input logic [31:0] data, input logic [31:0] flip,
                            input logic [3:0] rid, input logic err, input logic [31:0] exp_data);
    obi_r_t e;
    bus0.rel_rsp.rvalid      = rv;
    bus0.rel_rsp.r.rdata     = data ^ flip;
    bus0.rel_rsp.r.rdata_ecc = model_enc(data);
    bus0.rel_rsp.r.rid       = rid;
    bus0.rel_rsp.r.err       = err;
    bus0.rel_rsp.r.other_ecc = model_enc({27'b0, rid, err});
    if (tb_maj(rv)) begin
      e.rdata = exp_data; e.rid = rid; e.err = err;
      exp_r0.push_back(e);
    end
  endtask

  // Scoreboard monitors: pop and compare whenever a DUT output handshake occurs.
  always @(negedge clk) begin
    rel_a_t ea;
    obi_r_t er;
    if (rst === 1'b0) begin
      if (bus0.rel_req.req == 3'b111 && tb_maj(bus0.rel_rsp.gnt)) begin
        if (exp_a0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL req0_unexpected: got addr %0h, want no request", bus0.rel_req.a.addr);
        end else begin
          ea = exp_a0.pop_front();
          chk("req0_a", 128'(bus0.rel_req.a), 128'(ea));
        end
      end
      if (bus1.rel_req.req == 3'b111 && tb_maj(bus1.rel_rsp.gnt)) begin
        if (exp_a1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL req1_unexpected: got addr %0h, want no request", bus1.rel_req.a.addr);
        end else begin
          ea = exp_a1.pop_front();
          chk("req1_a", 128'(bus1.rel_req.a), 128'(ea));
        end
      end
      if (bus0.rsp.rvalid === 1'b1) begin
        if (exp_r0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp0_unexpected: got rdata %0h, want no response", bus0.rsp.r.rdata);
        end else begin
          er = exp_r0.pop_front();
          chk("rsp0_r", 128'(bus0.rsp.r), 128'(er));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clear0 = 1'b0; clear1 = 1'b0;
    bus0.req = '0; bus0.req.rready = 1'b1; bus0.rel_rsp = '0;
    bus1.req = '0; bus1.req.rready = 1'b1; bus1.rel_rsp = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_tmr0", 128'(tmr0), 0);
    chk("rst_corr0", 128'(corr0), 0);
    chk("rst_uncorr0", 128'(uncorr0), 0);
    chk("rst_proto0", 128'(proto0), 0);
    chk("rst_irq0", 128'(irq0), 0);
    chk("rst_relreq0", 128'(bus0.rel_req.req), 0);
    chk("rst_gnt1_empty", 128'(bus1.rsp.gnt), 1);
    chk("rst_relreq1", 128'(bus1.rel_req.req), 0);
    chk("rst_cnt1", 128'({tmr1, corr1, uncorr1, proto1, irq1}), 0);

    // Clean write
    drive_req0(1'b1, mk_a(32'h1000, 32'hDEAD_BEEF, 1'b1, 4'hF, 4'h3), 1'b1);
    bus0.rel_rsp.gnt = 3'b111;
    #1;
    chk("clean_gnt", 128'(bus0.rsp.gnt), 1);
    chk("clean_relreq", 128'(bus0.rel_req.req), 128'(3'b111));
    tick();
    drive_req0(1'b0, mk_a(0, 0, 0, 0, 0), 1'b0);
    bus0.rel_rsp.gnt = 3'b000;
    drive_rsp0(3'b111, 32'h1234_5678, 32'h0, 4'h3, 1'b0, 32'h1234_5678);
    tick();
    drive_rsp0(3'b000, 0, 0, 0, 0, 0);
    chk("clean_cnts", 128'({tmr0, corr0, uncorr0, proto0}), 0);
    chk("clean_irq", 128'(irq0), 0);

    // Single-bit rdata flip
    drive_req0(1'b1, mk_a(32'h1004, 32'h0, 1'b0, 4'h0, 4'h1), 1'b1);
    bus0.rel_rsp.gnt = 3'b111;
    tick();
    drive_req0(1'b0, mk_a(0, 0, 0, 0, 0), 1'b0);
    bus0.rel_rsp.gnt = 3'b000;
    drive_rsp0(3'b111, 32'hCAFE_F00D, 32'h20, 4'h2, 1'b0, 32'hCAFE_F00D);
    #1;
    chk("flip_irq_same_cycle", 128'(irq0), 0);
    tick();
    drive_rsp0(3'b000, 0, 0, 0, 0, 0);
    chk("flip_corr", 128'(corr0), 1);
    chk("flip_irq", 128'(irq0), 1);

    // Split gnt, then double-bit error
    drive_req0(1'b1, mk_a(32'h1008, 32'h55AA_55AA, 1'b1, 4'h3, 4'h2), 1'b1);
    bus0.rel_rsp.gnt = 3'b011;
    #1;
    chk("split_gnt", 128'(bus0.rsp.gnt), 1);
    tick();
    drive_req0(1'b0, mk_a(0, 0, 0, 0, 0), 1'b0);
    bus0.rel_rsp.gnt = 3'b000;
    chk("split_tmr", 128'(tmr0), 1);
    drive_rsp0(3'b111, 32'h0F0F_0F0F, 32'h3, 4'h1, 1'b1, 32'h0F0F_0F0C);
    tick();
    drive_rsp0(3'b000, 0, 0, 0, 0, 0);
    chk("dbl_uncorr", 128'(uncorr0), 1);
    chk("dbl_corr_kept", 128'(corr0), 1);

    // Outstanding limit (MaxOutstanding = 2)
    bus0.rel_rsp.gnt = 3'b111;
    drive_req0(1'b1, mk_a(32'h2000, 32'h1111_1111, 1'b1, 4'hF, 4'h0), 1'b1);
    tick();
    drive_req0(1'b1, mk_a(32'h2004, 32'h2222_2222, 1'b1, 4'hF, 4'h0), 1'b1);
    tick();
    drive_req0(1'b1, mk_a(32'h2008, 32'h3333_3333, 1'b1, 4'hF, 4'h0), 1'b1);
    #1;
    chk("lim_gnt", 128'(bus0.rsp.gnt), 0);
    chk("lim_relreq", 128'(bus0.rel_req.req), 0);
    tick();
    chk("lim_gnt_hold", 128'(bus0.rsp.gnt), 0);
    drive_rsp0(3'b111, 32'hA0A0_A0A0, 0, 4'h0, 1'b0, 32'hA0A0_A0A0);
    #1;
    chk("lim_relreq_rsp", 128'(bus0.rel_req.req), 0);
    tick();
    drive_rsp0(3'b000, 0, 0, 0, 0, 0);
    #1;
    chk("lim_regrant", 128'(bus0.rsp.gnt), 1);
    chk("lim_relreq_on", 128'(bus0.rel_req.req), 128'(3'b111));
    tick();
    drive_req0(1'b0, mk_a(0, 0, 0, 0, 0), 1'b0);
    bus0.rel_rsp.gnt = 3'b000;
    drive_rsp0(3'b111, 32'hB0B0_B0B0, 0, 4'h0, 1'b0, 32'hB0B0_B0B0);
    tick();
    drive_rsp0(3'b111, 32'hC0C0_C0C0, 0, 4'h0, 1'b0, 32'hC0C0_C0C0);
    tick();
    drive_rsp0(3'b000, 0, 0, 0, 0, 0);
    chk("lim_no_proto", 128'(proto0), 0);

    // Stray response
    drive_rsp0(3'b111, 32'h7777_7777, 0, 4'h5, 1'b0, 32'h7777_7777);
    tick();
    drive_rsp0(3'b000, 0, 0, 0, 0, 0);
    chk("stray_proto", 128'(proto0), 1);

    // Clear, saturation, clear with event
    clear0 = 1'b1;
    tick();
    clear0 = 1'b0;
    chk("clr_cnts", 128'({tmr0, corr0, uncorr0, proto0}), 0);
    chk("clr_irq", 128'(irq0), 0);
    for (int k = 0; k < 5; k++) begin
      drive_rsp0(3'b111, 32'h100 + k, 32'h1 << k, 4'h0, 1'b0, 32'h100 + k);
      tick();
    end
    drive_rsp0(3'b000, 0, 0, 0, 0, 0);
    chk("sat_corr", 128'(corr0), 3);
    chk("sat_proto", 128'(proto0), 3);
    clear0 = 1'b1;
    drive_rsp0(3'b111, 32'hABCD_0000, 32'h8000_0000, 4'h0, 1'b0, 32'hABCD_0000);
    tick();
    clear0 = 1'b0;
    drive_rsp0(3'b000, 0, 0, 0, 0, 0);
    chk("clrev_corr", 128'(corr0), 1);
    chk("clrev_proto", 128'(proto0), 1);
    chk("clrev_tmr", 128'(tmr0), 0);
    chk("clrev_irq", 128'(irq0), 1);

    // RegisterReq = 1: stall then streaming
    bus1.rel_rsp.gnt = 3'b000;
    drive_req1(1'b1, mk_a(32'h3000, 32'h0BAD_F00D, 1'b1, 4'hF, 4'h1), 1'b1);
    #1;
    chk("reg_gnt_empty", 128'(bus1.rsp.gnt), 1);
    chk("reg_relreq_empty", 128'(bus1.rel_req.req), 0);
    tick();
    drive_req1(1'b1, mk_a(32'h3004, 32'h1212_1212, 1'b0, 4'h3, 4'h2), 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_gnt", 128'(bus1.rsp.gnt), 0);
      chk("stall_relreq", 128'(bus1.rel_req.req), 128'(3'b111));
      chk("stall_a", 128'(bus1.rel_req.a),
          128'(model_a(mk_a(32'h3000, 32'h0BAD_F00D, 1'b1, 4'hF, 4'h1))));
      tick();
    end
    bus1.rel_rsp.gnt = 3'b111;
    #1;
    chk("stream_gnt0", 128'(bus1.rsp.gnt), 1);
    tick();
    drive_req1(1'b1, mk_a(32'h3008, 32'h3434_3434, 1'b1, 4'hC, 4'h3), 1'b1);
    #1;
    chk("stream_gnt1", 128'(bus1.rsp.gnt), 1);
    chk("stream_a2", 128'(bus1.rel_req.a),
        128'(model_a(mk_a(32'h3004, 32'h1212_1212, 1'b0, 4'h3, 4'h2))));
    tick();
    drive_req1(1'b0, mk_a(0, 0, 0, 0, 0), 1'b0);
    #1;
    chk("stream_relreq3", 128'(bus1.rel_req.req), 128'(3'b111));
    chk("stream_a3", 128'(bus1.rel_req.a),
        128'(model_a(mk_a(32'h3008, 32'h3434_3434, 1'b1, 4'hC, 4'h3))));
    tick();
    bus1.rel_rsp.gnt = 3'b000;
    #1;
    chk("stream_drained", 128'(bus1.rel_req.req), 0);
    tick();

    chk("q_req0_empty", 128'(exp_a0.size()), 0);
    chk("q_req1_empty", 128'(exp_a1.size()), 0);
    chk("q_rsp0_empty", 128'(exp_r0.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
